// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: feeds operands LSB-first to an external 1-bit ALU slice and assembles the result.
// Optional zero-result flag output enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [3:0]       slice_op,
    input  logic             slice_sum,
    input  logic             slice_cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_op_q;
    logic [CW-1:0]    r_cnt;
    logic             r_carry_q;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_op_legal;
    logic             w_arith;
    logic             w_last;

    // Reserved opcodes are latched as AND so the slice always sees a defined operation.
    always_comb begin
        w_op_legal = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT: w_op_legal = 1'b1;
            default:                                      w_op_legal = 1'b0;
        endcase
    end

    assign w_arith = (r_op_q == OP_ADD) || (r_op_q == OP_SUB) || (r_op_q == OP_SLT);
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_result  <= '0;
            r_op_q    <= '0;
            r_cnt     <= '0;
            r_carry_q <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // busy still high here means this is the done cycle; starts are ignored.
                S_IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_busy    <= 1'b1;
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_op_q    <= w_op_legal ? op : OP_AND;
                        r_cnt     <= '0;
                        r_carry_q <= (op == OP_SUB) || (op == OP_SLT);
                        r_cout    <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_zero    <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end
                // Operands drain to zero, so slice_a/slice_b fall to 0 once shifting ends.
                S_SHIFT: begin
                    r_result <= {slice_sum, r_result[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    if (w_last) begin
                        r_carry_q <= 1'b0;
                        r_cout    <= w_arith & slice_cout;
                        r_ovf     <= w_arith & (r_carry_q ^ slice_cout);
                        r_state   <= (r_op_q == OP_SLT) ? S_FIN : S_DONE;
                    end else begin
                        r_carry_q <= slice_cout;
                        r_cnt     <= r_cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    r_result <= {{(WIDTH-1){1'b0}}, r_result[WIDTH-1] ^ r_ovf};
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_zero  <= (r_result == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign slice_a   = r_a_sh[0];
    assign slice_b   = r_b_sh[0];
    assign slice_cin = r_carry_q;
    assign slice_op  = {1'b0, r_op_q};

`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign zero = r_zero;
`else
    logic w_zero_unused;
    assign w_zero_unused = r_zero;
`endif

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (legal range 2..64).
REQ-002 Port: clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request pulse; sampled only while busy=0.
REQ-005 Port: op  input  3  operation: 000 AND, 001 OR, 010 ADD, 100 XOR, 110 SUB, 111 SLT; other codes are reserved.
REQ-006 Port: a, b  input  WIDTH  operands, sampled on the start-accept edge.
REQ-007 Port: busy  output  1  high from the accept edge until the done cycle, inclusive.
REQ-008 Port: done  output  1  one-cycle pulse; result/cout/ovf are valid from this cycle.
REQ-009 Port: result  output  WIDTH  final result; held until the next accept.
REQ-010 Port: cout, ovf  output  1 each  final carry-out and signed overflow (ADD/SUB/SLT); 0 for logic ops.
REQ-011 Port: slice_a, slice_b, slice_cin  output  1 each  operand bits and carry to the external 1-bit ALU slice.
REQ-012 Port: slice_op  output  4  slice opcode = {1'b0, op_q}, where op_q is the op latched at accept.
REQ-013 Port: slice_sum, slice_cout  input  1 each  combinational slice outputs, sampled on each SHIFT-state edge.

Function
REQ-014 FSM states: IDLE, SHIFT, FIN, DONE; reset state is IDLE.
REQ-015 Accept: IDLE with start=1 -> latch a, b and op into a_sh, b_sh and op_q; cnt<=0; carry_q<=1 for SUB/SLT, else 0; go to SHIFT.
REQ-016 start while busy=1 is ignored (no queueing, no error).
REQ-017 In SHIFT: slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry_q; each edge shifts slice_sum into the result MSB, shifts a_sh/b_sh right, sets carry_q<=slice_cout and increments cnt.
REQ-018 On the edge with cnt=WIDTH-1, the block records cin_msb=carry_q and sum_msb=slice_sum, then goes to FIN if op_q=111, else to DONE.
REQ-019 FIN (SLT only, 1 cycle): result<={WIDTH-1 zeros, sum_msb^ovf}; then go to DONE.
REQ-020 ovf = cin_msb ^ final carry_q, forced to 0 for logic ops; cout = final carry_q.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; a start in DONE is ignored.
REQ-022 Latency, accept edge to done=1: WIDTH+1 cycles for non-SLT ops, WIDTH+2 for SLT.
REQ-023 In IDLE/FIN/DONE the slice inputs are driven to 0 and slice_op holds op_q.
REQ-024 A reserved op executes as AND; cout and ovf are 0.
REQ-025 cnt is sized $clog2(WIDTH) bits and never wraps inside an operation.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE and clears busy, done, result, cout, ovf, cnt, carry_q, a_sh, b_sh and op_q to 0.
REQ-027 Reset asserted mid-operation abandons the operation, and done does not pulse for it.
REQ-028 The first accept may occur on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_SERIAL_ZERO_FLAG_EN.
REQ-030 Defined: the block adds an output zero (1 bit), which is 1 when the final result is all zeros; it is valid with done, reset to 0, and evaluated after the FIN fix-up.
REQ-031 Undefined: the zero port and its logic are absent, and all other behaviour is identical.

Verification (WIDTH=32)
REQ-032 ADD a=0xFFFFFFFF, b=1 -> done at accept+33, result=0, cout=1, ovf=0.
REQ-033 SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, ovf=1, cout=1.
REQ-034 SLT a=0xFFFFFFFE (-2), b=3 -> done at accept+34, result=1; SLT a=5, b=5 -> result=0.
REQ-035 XOR a=0xA5A5A5A5, b=0xFFFF0000 -> result=0x5A5AA5A5, cout=0, ovf=0; a start pulsed mid-op is ignored and result is unchanged.
REQ-036 rst_n low at cnt=10 of an ADD -> busy=0 immediately and no done pulse; a new OR 0xF0, 0x0F -> result=0xFF.
REQ-037 With ALU_SERIAL_ZERO_FLAG_EN: SUB 7-7 -> zero=1; ADD 1+1 -> zero=0.
